// File: rtl/axis_fifo_pkg.sv
// Shared sizing helpers for the single-clock AXI-Stream FIFO.
// Pointers carry one extra wrap bit above the RAM address bits.
package axis_fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Stored word is {tlast, tdata}
  function automatic int word_w(input int data_w);
    return data_w + 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module fifo_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI-Stream FIFO with fill level, almost flags and optional
// store-and-forward packet mode.
module axis_sync_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 64,
  parameter int AFULL_THR  = 60,
  parameter int AEMPTY_THR = 4,
  parameter int PKT_MODE   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        s_axis_tdata,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     almost_empty
);

  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int ADDR_W = PTR_W - 1;
  localparam int WORD_W = word_w(DATA_W);

  localparam logic [PTR_W-1:0] AFULL_L  = PTR_W'(AFULL_THR);
  localparam logic [PTR_W-1:0] AEMPTY_L = PTR_W'(AEMPTY_THR);
  localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("axis_sync_fifo: DEPTH must be a power of 2 and at least 4");
  end
  if (!(AEMPTY_THR < AFULL_THR) || AFULL_THR > DEPTH) begin : g_bad_thr
    $error("axis_sync_fifo: need AEMPTY_THR < AFULL_THR <= DEPTH");
  end

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [PTR_W-1:0]  level_q, level_d;
  logic [PTR_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [WORD_W-1:0] rd_word;
  logic              full, empty, push, pop;

  assign full  = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                 (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
  assign empty = (wptr_q == rptr_q);

  assign s_axis_tready = !full && !rst;

  // Full override lets a packet longer than DEPTH trickle out instead of deadlocking
  assign m_axis_tvalid = (PKT_MODE != 0) ? (!empty && ((pkt_cnt_q != '0) || full))
                                         : !empty;

  assign push = s_axis_tvalid && s_axis_tready;
  assign pop  = m_axis_tvalid && m_axis_tready;

  fifo_ram #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q[ADDR_W-1:0]),
    .wdata ({s_axis_tlast, s_axis_tdata}),
    .raddr (rptr_q[ADDR_W-1:0]),
    .rdata (rd_word)
  );

  assign m_axis_tlast = rd_word[WORD_W-1];
  assign m_axis_tdata = rd_word[DATA_W-1:0];

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    level_d   = level_q;
    pkt_cnt_d = pkt_cnt_q;
    if (push) wptr_d = wptr_q + ONE;
    if (pop)  rptr_d = rptr_q + ONE;
    case ({push, pop})
      2'b10:   level_d = level_q + ONE;
      2'b01:   level_d = level_q - ONE;
      default: level_d = level_q;
    endcase
    case ({push && s_axis_tlast, pop && m_axis_tlast})
      2'b10:   pkt_cnt_d = pkt_cnt_q + ONE;
      2'b01:   pkt_cnt_d = pkt_cnt_q - ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      pkt_cnt_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign level        = level_q;
  assign almost_full  = (level_q >= AFULL_L);
  assign almost_empty = (level_q <= AEMPTY_L);

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed bench: cut-through instance for fill/drain/flags/wrap/reset,
// packet-mode instance for store-and-forward behaviour.
`timescale 1ns/1ps
module tb_axis_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] s_tdata, m_tdata;
  logic       s_tlast, s_tvalid, s_tready, m_tlast, m_tvalid, m_tready;
  logic [6:0] level;
  logic       afull, aempty;

  logic [7:0] p_s_tdata, p_m_tdata;
  logic       p_s_tlast, p_s_tvalid, p_s_tready, p_m_tlast, p_m_tvalid, p_m_tready;
  logic [6:0] p_level;
  logic       p_afull, p_aempty;

  int checks = 0;
  int errors = 0;
  int sent, recv, cyc;
  logic do_push, do_pop;

  always #5 clk = ~clk;

  axis_sync_fifo #(.DATA_W(8), .DEPTH(64), .AFULL_THR(60), .AEMPTY_THR(4), .PKT_MODE(0)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .level(level), .almost_full(afull), .almost_empty(aempty)
  );

  axis_sync_fifo #(.DATA_W(8), .DEPTH(64), .AFULL_THR(60), .AEMPTY_THR(4), .PKT_MODE(1)) dut_pkt (
    .clk(clk), .rst(rst),
    .s_axis_tdata(p_s_tdata), .s_axis_tlast(p_s_tlast), .s_axis_tvalid(p_s_tvalid), .s_axis_tready(p_s_tready),
    .m_axis_tdata(p_m_tdata), .m_axis_tlast(p_m_tlast), .m_axis_tvalid(p_m_tvalid), .m_axis_tready(p_m_tready),
    .level(p_level), .almost_full(p_afull), .almost_empty(p_aempty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s_tdata = '0; s_tlast = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
    p_s_tdata = '0; p_s_tlast = 1'b0; p_s_tvalid = 1'b0; p_m_tready = 1'b0;
    tick();
    check("rst_tready", s_tready, 0);
    check("rst_level", level, 0);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_aempty", aempty, 1);
    check("rst_afull", afull, 0);
    rst = 1'b0;
    tick();
    check("idle_tready", s_tready, 1);

    // Fill 64 beats with consumer stalled
    for (int i = 0; i < 64; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'(i);
      tick();
      check("fill_level", level, i + 1);
      if (i == 58) check("afull_at_59", afull, 0);
      if (i == 59) check("afull_at_60", afull, 1);
    end
    check("full_tready", s_tready, 0);
    s_tdata = 8'd64;
    tick();
    check("stall_level", level, 64);
    check("stall_head", m_tdata, 0);
    s_tvalid = 1'b0;

    // Drain in order
    m_tready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      check("drain_valid", m_tvalid, 1);
      check("drain_data", m_tdata, i);
      if (i == 59) check("aempty_at_5", aempty, 0);
      if (i == 60) check("aempty_at_4", aempty, 1);
      tick();
    end
    m_tready = 1'b0;
    check("drained_valid", m_tvalid, 0);
    check("drained_level", level, 0);

    // Steady push+pop at level 32
    for (int i = 0; i < 32; i++) begin
      s_tvalid = 1'b1; s_tdata = 8'(i);
      tick();
    end
    check("half_level", level, 32);
    m_tready = 1'b1;
    for (int j = 0; j < 100; j++) begin
      s_tdata = 8'(32 + j);
      check("both_data", m_tdata, j);
      tick();
      check("both_level", level, 32);
    end
    s_tvalid = 1'b0; m_tready = 1'b0;
    check("both_head", m_tdata, 100);

    // Short asynchronous reset pulse mid-stream
    rst = 1'b1;
    #0.01;
    check("pulse_tready", s_tready, 0);
    check("pulse_level", level, 0);
    check("pulse_tvalid", m_tvalid, 0);
    check("pulse_aempty", aempty, 1);
    rst = 1'b0;
    tick();
    check("post_rst_tready", s_tready, 1);
    check("post_rst_level", level, 0);

    // Streaming across three pointer wraps with irregular consumer
    sent = 0; recv = 0; cyc = 0;
    while (recv < 192 && cyc < 3000) begin
      s_tvalid = (sent < 192); s_tdata = 8'(sent);
      m_tready = 1'($urandom_range(0, 1));
      do_push = s_tvalid && s_tready;
      do_pop  = m_tvalid && m_tready;
      if (do_pop) check("wrap_data", m_tdata, 32'(recv % 256));
      tick();
      if (do_push) sent++;
      if (do_pop) recv++;
      cyc++;
    end
    s_tvalid = 1'b0; m_tready = 1'b0;
    check("wrap_count", recv, 192);
    check("wrap_level", level, 0);

    // Packet mode: held until tlast arrives
    for (int k = 0; k < 5; k++) begin
      p_s_tvalid = 1'b1; p_s_tdata = 8'(8'hA0 + k); p_s_tlast = 1'b0;
      tick();
      check("pkt_hold_valid", p_m_tvalid, 0);
    end
    p_s_tdata = 8'hA5; p_s_tlast = 1'b1;
    tick();
    p_s_tvalid = 1'b0; p_s_tlast = 1'b0;
    check("pkt_release_valid", p_m_tvalid, 1);
    check("pkt_level", p_level, 6);
    p_m_tready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("pkt_data", p_m_tdata, 32'hA0 + k);
      check("pkt_tlast", p_m_tlast, (k == 5) ? 1 : 0);
      tick();
    end
    p_m_tready = 1'b0;
    check("pkt_done_valid", p_m_tvalid, 0);

    // Oversized packet drains through the full override
    for (int k = 0; k < 64; k++) begin
      p_s_tvalid = 1'b1; p_s_tdata = 8'(k); p_s_tlast = 1'b0;
      tick();
      if (k == 62) check("big_hold_valid", p_m_tvalid, 0);
    end
    check("big_full_valid", p_m_tvalid, 1);
    check("big_full_level", p_level, 64);
    sent = 64; recv = 0; cyc = 0;
    p_m_tready = 1'b1;
    while (recv < 70 && cyc < 1000) begin
      p_s_tvalid = (sent < 70); p_s_tdata = 8'(sent); p_s_tlast = (sent == 69);
      do_push = p_s_tvalid && p_s_tready;
      do_pop  = p_m_tvalid && p_m_tready;
      if (do_pop) begin
        check("big_data", p_m_tdata, recv);
        check("big_tlast", p_m_tlast, (recv == 69) ? 1 : 0);
      end
      tick();
      if (do_push) sent++;
      if (do_pop) recv++;
      cyc++;
    end
    p_s_tvalid = 1'b0; p_s_tlast = 1'b0; p_m_tready = 1'b0;
    check("big_count", recv, 70);
    check("big_level", p_level, 0);
    check("big_end_valid", p_m_tvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
